// File: rtl/dezigzag_buffer.sv
// Zigzag-to-raster reorder buffer, two 64-entry ping-pong banks.
// Optional: DEZIGZAG_TRANSPOSE_EN selects column-major readout.
module dezigzag_buffer #(
  parameter int W     = 12,
  parameter int BANKS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  logic [W-1:0] r_mem [BANKS*64];
  logic [1:0]   r_full;
  logic [1:0]   w_full_nxt;
  logic         r_wbank;
  logic         r_rbank;
  logic [5:0]   r_widx;
  logic [5:0]   r_ridx;
  logic [5:0]   w_zz;
  logic [5:0]   w_raddr;
  logic         w_acc;
  logic         w_adv;
  logic         w_iss;

  assign in_ready = ~r_full[r_wbank];
  assign w_acc    = in_valid & in_ready;
  assign w_adv    = ~out_valid | out_ready;
  assign w_iss    = w_adv & r_full[r_rbank];

`ifdef DEZIGZAG_TRANSPOSE_EN
  assign w_raddr = {r_ridx[2:0], r_ridx[5:3]};
`else
  assign w_raddr = r_ridx;
`endif

  // zigzag index -> raster position ROM
  always_comb begin
    w_zz = 6'd0;
    case (r_widx)
      6'd0:  w_zz = 6'd0;   6'd1:  w_zz = 6'd1;
      6'd2:  w_zz = 6'd8;   6'd3:  w_zz = 6'd16;
      6'd4:  w_zz = 6'd9;   6'd5:  w_zz = 6'd2;
      6'd6:  w_zz = 6'd3;   6'd7:  w_zz = 6'd10;
      6'd8:  w_zz = 6'd17;  6'd9:  w_zz = 6'd24;
      6'd10: w_zz = 6'd32;  6'd11: w_zz = 6'd25;
      6'd12: w_zz = 6'd18;  6'd13: w_zz = 6'd11;
      6'd14: w_zz = 6'd4;   6'd15: w_zz = 6'd5;
      6'd16: w_zz = 6'd12;  6'd17: w_zz = 6'd19;
      6'd18: w_zz = 6'd26;  6'd19: w_zz = 6'd33;
      6'd20: w_zz = 6'd40;  6'd21: w_zz = 6'd48;
      6'd22: w_zz = 6'd41;  6'd23: w_zz = 6'd34;
      6'd24: w_zz = 6'd27;  6'd25: w_zz = 6'd20;
      6'd26: w_zz = 6'd13;  6'd27: w_zz = 6'd6;
      6'd28: w_zz = 6'd7;   6'd29: w_zz = 6'd14;
      6'd30: w_zz = 6'd21;  6'd31: w_zz = 6'd28;
      6'd32: w_zz = 6'd35;  6'd33: w_zz = 6'd42;
      6'd34: w_zz = 6'd49;  6'd35: w_zz = 6'd56;
      6'd36: w_zz = 6'd57;  6'd37: w_zz = 6'd50;
      6'd38: w_zz = 6'd43;  6'd39: w_zz = 6'd36;
      6'd40: w_zz = 6'd29;  6'd41: w_zz = 6'd22;
      6'd42: w_zz = 6'd15;  6'd43: w_zz = 6'd23;
      6'd44: w_zz = 6'd30;  6'd45: w_zz = 6'd37;
      6'd46: w_zz = 6'd44;  6'd47: w_zz = 6'd51;
      6'd48: w_zz = 6'd58;  6'd49: w_zz = 6'd59;
      6'd50: w_zz = 6'd52;  6'd51: w_zz = 6'd45;
      6'd52: w_zz = 6'd38;  6'd53: w_zz = 6'd31;
      6'd54: w_zz = 6'd39;  6'd55: w_zz = 6'd46;
      6'd56: w_zz = 6'd53;  6'd57: w_zz = 6'd60;
      6'd58: w_zz = 6'd61;  6'd59: w_zz = 6'd54;
      6'd60: w_zz = 6'd47;  6'd61: w_zz = 6'd55;
      6'd62: w_zz = 6'd62;  6'd63: w_zz = 6'd63;
      default: w_zz = 6'd0;
    endcase
  end

  // bank flags: set on last write, clear on last read (always different banks)
  always_comb begin
    w_full_nxt = r_full;
    if (w_acc && r_widx == 6'd63)
      w_full_nxt[r_wbank] = 1'b1;
    if (w_iss && r_ridx == 6'd63)
      w_full_nxt[r_rbank] = 1'b0;
  end

  // coefficient store, written at its raster slot
  always_ff @(posedge clk) begin
    if (w_acc)
      r_mem[{r_wbank, w_zz}] <= in_data;
  end

  // write-side index and bank pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_widx  <= 6'd0;
      r_wbank <= 1'b0;
      r_full  <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (w_acc) begin
        r_widx <= r_widx + 6'd1;
        if (r_widx == 6'd63)
          r_wbank <= ~r_wbank;
      end
    end
  end

  // read side: issue when output register is free and bank is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ridx    <= 6'd0;
      r_rbank   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (w_iss) begin
      out_data  <= r_mem[{r_rbank, w_raddr}];
      out_valid <= 1'b1;
      out_last  <= (r_ridx == 6'd63);
      r_ridx    <= r_ridx + 6'd1;
      if (r_ridx == 6'd63)
        r_rbank <= ~r_rbank;
    end else if (w_adv) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
